uart_tx_drain: RTL and testbench

- UART transmitter that drains the byte fifo of the buffered UART, serializing each byte onto a single tx line.
- Sits downstream of fifo: pops one entry, captures it from the fifo's registered data output, sends one 8N1-style frame, and repeats while entries remain.
- This is the consumer (reader) side of the fifo interface.

---
 rtl/uart_tx_drain.sv | 150 +++++++++++++++
 tb/tb_uart_tx_drain.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops bytes from the buffered-UART fifo and serialises each one, LSB first, onto tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_drain #(
  parameter int data_width     = 8,
  parameter int clocks_per_bit = 16,
  parameter int stop_bits      = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [data_width-1:0] fifo_data,
  output logic                  tx,
  output logic                  busy
);

  localparam int BAUD_W = (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
  localparam int BIT_W  = $clog2(data_width + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(clocks_per_bit - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(data_width - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(stop_bits - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] POP    = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd6;
`endif

  logic [2:0]            state;
  logic [data_width-1:0] shift;
  logic [data_width-1:0] shift_nxt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BAUD_W-1:0]     baud;
  logic                  baud_done;
  logic                  start_ok;
`ifdef UART_TX_PARITY_EN
  logic                  par_bit;

  function automatic logic even_parity(input logic [data_width-1:0] d);
    return ^d;
  endfunction
`endif

  assign baud_done = (baud == BAUD_LAST);
  assign start_ok  = enable && !fifo_empty;
  assign shift_nxt = shift >> 1;
  assign fifo_pop  = (state == POP);
  assign busy      = (state != IDLE);

  // fifo_data is the fifo's registered output, so it is only valid in LOAD, one cycle after the pop.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      baud    <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (start_ok) state <= POP;
        end
        POP: begin
          state <= LOAD;
        end
        LOAD: begin
          shift <= fifo_data;
`ifdef UART_TX_PARITY_EN
          par_bit <= even_parity(fifo_data);
`endif
          tx    <= 1'b0;
          baud  <= '0;
          state <= START;
        end
        START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_cnt <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx      <= par_bit;
              state   <= PARITY;
`else
              tx      <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              shift   <= shift_nxt;
              bit_cnt <= bit_cnt + BIT_W'(1);
              tx      <= shift_nxt[0];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud    <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
            state   <= STOP;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          // bit_cnt is reused here to count stop bits; the restart decision is taken on the last cycle.
          if (baud_done) begin
            baud <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= start_ok ? POP : IDLE;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: a frame-level reference model compared every cycle, plus directed literal checks.
module tb_uart_tx_drain;

  localparam int CPB = 4;
  localparam int DW  = 8;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB  = 1;
`else
  localparam int PB  = 0;
`endif
  localparam int FRAME = (1 + DW + PB + SB) * CPB;
  localparam int HIST  = 4096;

  logic       clock      = 1'b0;
  logic       resetn     = 1'b0;
  logic       enable     = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data  = 8'h00;
  logic       fifo_pop;
  logic       tx;
  logic       busy;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int pop_count = 0;

  logic       txh   [HIST];
  logic       busyh [HIST];
  logic [7:0] fq    [$];
  logic [2:0] seq   [$];
  logic [7:0] popped       = 8'h00;
  logic       load_pending = 1'b0;

`ifdef UART_TX_PARITY_EN
  string pat_a5 = "01010010101";
  string pat_01 = "01000000011";
  string pat_ff = "01111111101";
  string pat_3c = "00011110001";
  string pat_5a = "00101101001";
`else
  string pat_a5 = "0101001011";
  string pat_01 = "0100000001";
  string pat_ff = "0111111111";
  string pat_3c = "0001111001";
  string pat_5a = "0010110101";
`endif

  uart_tx_drain #(
    .data_width    (DW),
    .clocks_per_bit(CPB),
    .stop_bits     (SB)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .enable    (enable),
    .fifo_empty(fifo_empty),
    .fifo_pop  (fifo_pop),
    .fifo_data (fifo_data),
    .tx        (tx),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  // Expected {tx,busy,fifo_pop} per cycle: POP, LOAD, then every frame bit held CPB cycles.
  task automatic build_frame(input logic [7:0] d);
    logic lv[$];
    seq.push_back(3'b111);
    seq.push_back(3'b110);
    lv.push_back(1'b0);
    for (int i = 0; i < DW; i++) lv.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    lv.push_back(^d);
`endif
    for (int i = 0; i < SB; i++) lv.push_back(1'b1);
    foreach (lv[k]) repeat (CPB) seq.push_back({lv[k], 1'b1, 1'b0});
  endtask

  // Fifo model, history recorder and per-cycle comparison, all on the falling edge.
  initial begin : cmp
    logic [2:0] exp_v;
    forever begin
      @(negedge clock);
      cyc++;
      if (cyc < HIST) begin
        txh[cyc]   = tx;
        busyh[cyc] = busy;
      end
      if (fifo_pop) pop_count++;
      if (load_pending) begin
        fifo_data    = popped;
        load_pending = 1'b0;
      end
      if (fifo_pop && fq.size() > 0) begin
        popped       = fq.pop_front();
        load_pending = 1'b1;
      end
      fifo_empty = (fq.size() == 0);
      if (!resetn) begin
        seq.delete();
        exp_v = 3'b100;
      end else if (seq.size() == 0) begin
        exp_v = 3'b100;
      end else begin
        exp_v = seq.pop_front();
      end
      check($sformatf("cycle%0d_tx_busy_pop", cyc), int'({tx, busy, fifo_pop}), int'(exp_v));
      if (resetn && seq.size() == 0 && enable && !fifo_empty) build_frame(fq[0]);
    end
  end

  function automatic int find_fall(input int from);
    for (int i = (from < 1 ? 1 : from); i <= cyc && i < HIST; i++)
      if (txh[i] == 1'b0 && txh[i-1] == 1'b1) return i;
    return -1;
  endfunction

  function automatic int find_busy_drop(input int from);
    for (int i = from + 1; i <= cyc && i < HIST; i++)
      if (busyh[i] == 1'b0) return i;
    return -1;
  endfunction

  task automatic check_frame(input string nm, input int f, input string pat);
    int idx;
    if (f < 0) begin
      check({nm, "_start_found"}, 0, 1);
      return;
    end
    for (int k = 0; k < pat.len(); k++) begin
      idx = f + CPB * k + CPB / 2;
      if (idx > cyc || idx >= HIST) check($sformatf("%s_bit%0d_recorded", nm, k), 0, 1);
      else check($sformatf("%s_bit%0d", nm, k), int'(txh[idx]), int'(pat.getc(k) == 8'h31));
    end
  endtask

  task automatic send_and_check(input string nm, input logic [7:0] b, input string pat);
    int p, f, pops0;
    @(posedge clock); #1;
    pops0 = pop_count;
    fq.push_back(b);
    p = cyc + 1;
    repeat (FRAME + 16) @(posedge clock);
    #1;
    f = find_fall(p);
    check({nm, "_latency"}, f - p, 3);
    check({nm, "_pops"}, pop_count - pops0, 1);
    check_frame(nm, f, pat);
    check({nm, "_busy_len"}, find_busy_drop(f) - f, FRAME);
  endtask

  initial begin : stim
    int p, f, f2, sb, pops0;

    // reset hold, then idle with an empty fifo
    repeat (3) @(posedge clock);
    #1;
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_pop", int'(fifo_pop), 0);
    resetn = 1'b1;
    enable = 1'b1;
    pops0  = pop_count;
    repeat (20) @(posedge clock);
    #1;
    check("idle_pops", pop_count - pops0, 0);
    check("idle_tx", int'(tx), 1);
    check("idle_busy", int'(busy), 0);

    send_and_check("a5", 8'hA5, pat_a5);

    // back-to-back frames
    @(posedge clock); #1;
    pops0 = pop_count;
    fq.push_back(8'h01);
    fq.push_back(8'hFF);
    p = cyc + 1;
    repeat (2 * FRAME + 24) @(posedge clock);
    #1;
    f  = find_fall(p);
    check("b2b_latency", f - p, 3);
    check_frame("b2b_01", f, pat_01);
    sb = f + FRAME - SB * CPB;
    f2 = find_fall(sb);
    check("b2b_gap", f2 - sb, SB * CPB + 2);
    check_frame("b2b_ff", f2, pat_ff);
    check("b2b_busy_len", find_busy_drop(f2) - f2, FRAME);
    check("b2b_pops", pop_count - pops0, 2);

    // enable dropped mid-frame with the fifo still holding a byte
    @(posedge clock); #1;
    pops0 = pop_count;
    fq.push_back(8'h3C);
    fq.push_back(8'h99);
    p = cyc + 1;
    repeat (12) @(posedge clock);
    #1;
    enable = 1'b0;
    repeat (FRAME + 12) @(posedge clock);
    #1;
    f = find_fall(p);
    check("en_off_latency", f - p, 3);
    check_frame("en_off_3c", f, pat_3c);
    check("en_off_busy_len", find_busy_drop(f) - f, FRAME);
    check("en_off_pops", pop_count - pops0, 1);
    check("en_off_busy_end", int'(busy), 0);
    fq.delete();
    repeat (2) @(posedge clock);
    #1;
    enable = 1'b1;

    // asynchronous reset during data bit 3 of 0xC3, then 0x5A goes out cleanly
    @(posedge clock); #1;
    pops0 = pop_count;
    fq.push_back(8'hC3);
    fq.push_back(8'h5A);
    repeat (20) @(posedge clock);
    #3;
    check("rst_pre_tx", int'(tx), 0);
    resetn = 1'b0;
    #1;
    check("rst_async_tx", int'(tx), 1);
    check("rst_async_busy", int'(busy), 0);
    @(posedge clock); #1;
    resetn = 1'b1;
    p = cyc + 1;
    repeat (FRAME + 16) @(posedge clock);
    #1;
    f = find_fall(p);
    check("rst_5a_latency", f - p, 3);
    check_frame("rst_5a", f, pat_5a);
    check("rst_5a_busy_len", find_busy_drop(f) - f, FRAME);
    check("rst_pops", pop_count - pops0, 2);

`ifdef UART_TX_PARITY_EN
    send_and_check("par07", 8'h07, "01110000011");
    send_and_check("par03", 8'h03, "01100000001");
    check("par_frame_len", FRAME, 44);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog");
  end

endmodule
